// File: rtl/cordic_vectoring_iter_if.sv
// Handshake/result bundle for cordic_vectoring_iter.
// master: the producer of vectors / consumer of results (testbench or upstream logic).
// slave : the CORDIC engine itself.
interface cordic_vectoring_iter_if;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] angle;
    logic        [16:0] magnitude;
    logic               out_valid;

    modport master (
        output x_in, y_in, in_valid,
        input  in_ready, angle, magnitude, out_valid
    );

    modport slave (
        input  x_in, y_in, in_valid,
        output in_ready, angle, magnitude, out_valid
    );
endinterface

// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring-mode CORDIC: (x, y) in Q2.14 -> angle = atan2(y, x) in Q3.13
// radians and magnitude in Q3.14. A single shift/add datapath performs one
// micro-rotation per cycle. Inputs are pre-rotated into the right half-plane so the
// iteration always converges.
// Optional feature macro: GAIN_COMP_EN -- adds a SCALE cycle that multiplies the
// raw magnitude by 1/K so the result is the true vector length. Without it the
// magnitude carries the CORDIC gain K (~1.64676) and no multiplier exists.
module cordic_vectoring_iter #(
    parameter int ITERATIONS = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    cordic_vectoring_iter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROTATE = 2'd1,
        S_SCALE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ITER = 4'(ITERATIONS - 1);

    state_t             state_q, state_d;
    logic        [3:0]  iter_q, iter_d;
    logic signed [17:0] x_q, x_d;
    logic signed [17:0] y_q, y_d;
    logic signed [16:0] z_q, z_d;
    logic               zero_q, zero_d;
    logic signed [15:0] angle_q, angle_d;
    logic        [16:0] magnitude_q, magnitude_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    logic signed [17:0] x_ext_s, y_ext_s;
    logic signed [17:0] pre_x_s, pre_y_s;
    logic signed [16:0] pre_z_s;
    logic signed [17:0] x_sh_s, y_sh_s;
    logic signed [16:0] atan_s;
    logic signed [17:0] rot_x_s, rot_y_s;
    logic signed [16:0] rot_z_s;

    // atan(2^-i) in Q3.13, rounded; entry 14 rounds to zero
    function automatic logic signed [16:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_lut = 17'sd6434;
            4'd1:    atan_lut = 17'sd3798;
            4'd2:    atan_lut = 17'sd2007;
            4'd3:    atan_lut = 17'sd1019;
            4'd4:    atan_lut = 17'sd511;
            4'd5:    atan_lut = 17'sd256;
            4'd6:    atan_lut = 17'sd128;
            4'd7:    atan_lut = 17'sd64;
            4'd8:    atan_lut = 17'sd32;
            4'd9:    atan_lut = 17'sd16;
            4'd10:   atan_lut = 17'sd8;
            4'd11:   atan_lut = 17'sd4;
            4'd12:   atan_lut = 17'sd2;
            4'd13:   atan_lut = 17'sd1;
            default: atan_lut = 17'sd0;
        endcase
    endfunction

`ifdef GAIN_COMP_EN
    logic [31:0] prod_s;
    logic [16:0] scaled_s;

    // Gain compensation: |v| = x * round(2^15 / K) >> 15 (x is non-negative here)
    always_comb begin
        prod_s   = 32'(x_q[16:0]) * 32'd19898;
        scaled_s = 17'(prod_s >> 15);
    end
`endif

    // Fold left-half-plane inputs by +/-90 degrees so x' >= 0 before iterating
    always_comb begin
        x_ext_s = 18'(bus.x_in);
        y_ext_s = 18'(bus.y_in);
        if (!bus.x_in[15]) begin
            pre_x_s = x_ext_s;
            pre_y_s = y_ext_s;
            pre_z_s = 17'sd0;
        end else if (!bus.y_in[15]) begin
            pre_x_s = y_ext_s;
            pre_y_s = 18'sd0 - x_ext_s;
            pre_z_s = 17'sd12868;
        end else begin
            pre_x_s = 18'sd0 - y_ext_s;
            pre_y_s = x_ext_s;
            pre_z_s = -17'sd12868;
        end
    end

    // One micro-rotation driving y toward zero; the sign of y picks the direction
    always_comb begin
        x_sh_s = x_q >>> iter_q;
        y_sh_s = y_q >>> iter_q;
        atan_s = atan_lut(iter_q);
        if (!y_q[17]) begin
            rot_x_s = x_q + y_sh_s;
            rot_y_s = y_q - x_sh_s;
            rot_z_s = z_q + atan_s;
        end else begin
            rot_x_s = x_q - y_sh_s;
            rot_y_s = y_q + x_sh_s;
            rot_z_s = z_q - atan_s;
        end
    end

    // Next-state and output logic of the IDLE/ROTATE/SCALE sequencer
    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        zero_d      = zero_q;
        angle_d     = angle_q;
        magnitude_d = magnitude_q;
        out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d = S_ROTATE;
                    iter_d  = 4'd0;
                    x_d     = pre_x_s;
                    y_d     = pre_y_s;
                    z_d     = pre_z_s;
                    zero_d  = (bus.x_in == 16'sd0) && (bus.y_in == 16'sd0);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ROTATE: begin
                x_d = rot_x_s;
                y_d = rot_y_s;
                z_d = rot_z_s;
                if (iter_q == LAST_ITER) begin
                    iter_d = 4'd0;
`ifdef GAIN_COMP_EN
                    state_d = S_SCALE;
`else
                    // The last rotation edge is also the output edge
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    if (zero_q) begin
                        angle_d     = 16'sd0;
                        magnitude_d = 17'd0;
                    end else begin
                        angle_d     = rot_z_s[15:0];
                        magnitude_d = rot_x_s[16:0];
                    end
`endif
                end else begin
                    iter_d  = iter_q + 4'd1;
                    state_d = S_ROTATE;
                end
            end
            S_SCALE: begin
                state_d = S_IDLE;
`ifdef GAIN_COMP_EN
                out_valid_d = 1'b1;
                if (zero_q) begin
                    angle_d     = 16'sd0;
                    magnitude_d = 17'd0;
                end else begin
                    angle_d     = z_q[15:0];
                    magnitude_d = scaled_s;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                iter_d  = 4'd0;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            iter_q      <= 4'd0;
            x_q         <= 18'sd0;
            y_q         <= 18'sd0;
            z_q         <= 17'sd0;
            zero_q      <= 1'b0;
            angle_q     <= 16'sd0;
            magnitude_q <= 17'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            zero_q      <= zero_d;
            angle_q     <= angle_d;
            magnitude_q <= magnitude_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.angle     = angle_q;
    assign bus.magnitude = magnitude_q;

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Self-checking bench for cordic_vectoring_iter. Reference: integer CORDIC
// algorithm plus real-valued atan2/sqrt sanity bounds. Honours GAIN_COMP_EN.
module tb_cordic_vectoring_iter;

    localparam int ITER = 14;
`ifdef GAIN_COMP_EN
    localparam int LAT = ITER + 2;
`else
    localparam int LAT = ITER + 1;
`endif

    logic clk;
    logic rst;
    int   n_vec;
    int   n_fail;

    int atan_tab[15] = '{6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0};

    cordic_vectoring_iter_if bus ();

    cordic_vectoring_iter #(.ITERATIONS(ITER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Algorithmic reference: quadrant fold, ITER micro-rotations, optional 1/K scale
    function automatic void ref_model(input int xi, input int yi, output int ang, output int mag);
        int x, y, z, xn;
        if (xi == 0 && yi == 0) begin
            ang = 0;
            mag = 0;
            return;
        end
        if (xi >= 0)      begin x = xi;  y = yi;  z = 0;      end
        else if (yi >= 0) begin x = yi;  y = -xi; z = 12868;  end
        else              begin x = -yi; y = xi;  z = -12868; end
        for (int i = 0; i < ITER; i++) begin
            if (y >= 0) begin
                xn = x + (y >>> i); y = y - (x >>> i); z = z + atan_tab[i];
            end else begin
                xn = x - (y >>> i); y = y + (x >>> i); z = z - atan_tab[i];
            end
            x = xn;
        end
        ang = z;
`ifdef GAIN_COMP_EN
        mag = int'((longint'(x) * 64'sd19898) >>> 15);
`else
        mag = x;
`endif
    endfunction

    function automatic int ideal_angle(input int xi, input int yi);
        real a;
        a = $atan2(real'(yi), real'(xi)) * 8192.0;
        return $rtoi(a >= 0.0 ? a + 0.5 : a - 0.5);
    endfunction

    function automatic int ideal_mag(input int xi, input int yi);
        real m;
        m = $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi));
`ifndef GAIN_COMP_EN
        m = m * 1.64676;
`endif
        return $rtoi(m + 0.5);
    endfunction

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Issue one vector from idle and wait (bounded) for its result
    task automatic run_vec(input int xi, input int yi, output int lat, output int ang_o, output int mag_o);
        bus.x_in     = 16'(xi);
        bus.y_in     = 16'(yi);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < LAT + 20) begin
            tick();
            lat++;
        end
        ang_o = int'(bus.angle);
        mag_o = int'(bus.magnitude);
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.x_in     = 16'sd0;
        bus.y_in     = 16'sd0;
        tick();
        tick();
        n_vec++; if (bus.in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        n_vec++; if (bus.angle !== 16'sd0)    begin n_fail++; $display("FAIL reset_angle got %0d exp 0", bus.angle); end
        n_vec++; if (bus.magnitude !== 17'd0) begin n_fail++; $display("FAIL reset_magnitude got %0d exp 0", bus.magnitude); end
        #2 rst = 1'b0;
        tick();
    endtask

    typedef struct { int x; int y; int atol; int mtol; } dvec_t;

    task automatic test_directed();
        dvec_t tab[7] = '{
            '{16384, 0, 4, 8}, '{0, 16384, 4, 8}, '{-16384, 0, 4, 8},
            '{-16384, -16384, 4, 12}, '{0, 0, 0, 0}, '{-32768, 0, 8, 24},
            '{5000, -7000, 6, 16}
        };
        int lat, ang, mag, ea, em, ia, im;
        for (int k = 0; k < 7; k++) begin
            ref_model(tab[k].x, tab[k].y, ea, em);
            ia = ideal_angle(tab[k].x, tab[k].y);
            im = ideal_mag(tab[k].x, tab[k].y);
            run_vec(tab[k].x, tab[k].y, lat, ang, mag);
            n_vec++; if (lat !== LAT) begin n_fail++; $display("FAIL dir_latency[%0d] got %0d exp %0d", k, lat, LAT); end
            n_vec++; if (ang !== ea)  begin n_fail++; $display("FAIL dir_angle[%0d] got %0d exp %0d", k, ang, ea); end
            n_vec++; if (mag !== em)  begin n_fail++; $display("FAIL dir_mag[%0d] got %0d exp %0d", k, mag, em); end
            n_vec++; if (absi(ang - ia) > tab[k].atol) begin n_fail++; $display("FAIL dir_angle_ideal[%0d] got %0d exp %0d+/-%0d", k, ang, ia, tab[k].atol); end
            n_vec++; if (absi(mag - im) > tab[k].mtol) begin n_fail++; $display("FAIL dir_mag_ideal[%0d] got %0d exp %0d+/-%0d", k, mag, im, tab[k].mtol); end
            tick();
            n_vec++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL dir_pulse_width[%0d] got %b exp 0", k, bus.out_valid); end
            n_vec++; if (int'(bus.angle) !== ea || int'(bus.magnitude) !== em) begin
                n_fail++; $display("FAIL dir_hold[%0d] got %0d/%0d exp %0d/%0d", k, bus.angle, bus.magnitude, ea, em);
            end
        end
    endtask

    task automatic test_random();
        logic signed [15:0] rx, ry;
        int lat, ang, mag, ea, em, gap;
        for (int k = 0; k < 30; k++) begin
            rx  = 16'($urandom);
            ry  = 16'($urandom);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            ref_model(int'(rx), int'(ry), ea, em);
            run_vec(int'(rx), int'(ry), lat, ang, mag);
            n_vec++; if (lat !== LAT) begin n_fail++; $display("FAIL rnd_latency (%0d,%0d) got %0d exp %0d", rx, ry, lat, LAT); end
            n_vec++; if (ang !== ea)  begin n_fail++; $display("FAIL rnd_angle (%0d,%0d) got %0d exp %0d", rx, ry, ang, ea); end
            n_vec++; if (mag !== em)  begin n_fail++; $display("FAIL rnd_mag (%0d,%0d) got %0d exp %0d", rx, ry, mag, em); end
            tick();
        end
    endtask

    // in_valid held high with new operands every cycle; only accept-cycle operands count
    task automatic test_back_to_back();
        int qa[$];
        int qm[$];
        int ea, em, cur_a, cur_m;
        logic signed [15:0] rx, ry;
        bit have_cur;
        have_cur = 1'b0;
        cur_a = 0;
        cur_m = 0;
        for (int c = 0; c <= 4 * LAT; c++) begin
            n_vec++; if (bus.in_ready !== ((c % LAT) == 0)) begin n_fail++; $display("FAIL b2b_in_ready c=%0d got %b exp %b", c, bus.in_ready, (c % LAT) == 0); end
            n_vec++; if (bus.out_valid !== (c > 0 && (c % LAT) == 0)) begin n_fail++; $display("FAIL b2b_out_valid c=%0d got %b", c, bus.out_valid); end
            if (c > 0 && (c % LAT) == 0 && qa.size() > 0) begin
                cur_a = qa.pop_front();
                cur_m = qm.pop_front();
                have_cur = 1'b1;
            end
            if (have_cur) begin
                n_vec++; if (int'(bus.angle) !== cur_a || int'(bus.magnitude) !== cur_m) begin
                    n_fail++; $display("FAIL b2b_result c=%0d got %0d/%0d exp %0d/%0d", c, bus.angle, bus.magnitude, cur_a, cur_m);
                end
            end
            rx = 16'($urandom);
            ry = 16'($urandom);
            bus.x_in     = rx;
            bus.y_in     = ry;
            bus.in_valid = (c < 4 * LAT);
            if ((c % LAT) == 0 && c < 4 * LAT) begin
                ref_model(int'(rx), int'(ry), ea, em);
                qa.push_back(ea);
                qm.push_back(em);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, ang, mag, ea, em;
        run_vec(16384, 16384, lat, ang, mag);
        tick();
        bus.x_in     = 16'sd12000;
        bus.y_in     = -16'sd3000;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        #2 rst = 1'b1;
        #1;
        n_vec++; if (bus.in_ready !== 1'b1)   begin n_fail++; $display("FAIL mid_rst_in_ready got %b exp 1", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_out_valid got %b exp 0", bus.out_valid); end
        n_vec++; if (bus.angle !== 16'sd0)    begin n_fail++; $display("FAIL mid_rst_angle got %0d exp 0", bus.angle); end
        n_vec++; if (bus.magnitude !== 17'd0) begin n_fail++; $display("FAIL mid_rst_magnitude got %0d exp 0", bus.magnitude); end
        #1 rst = 1'b0;
        for (int k = 0; k < LAT + 4; k++) begin
            tick();
            n_vec++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_pulse cyc=%0d got %b exp 0", k, bus.out_valid); end
        end
        ref_model(-9000, 7000, ea, em);
        run_vec(-9000, 7000, lat, ang, mag);
        n_vec++; if (lat !== LAT) begin n_fail++; $display("FAIL post_rst_latency got %0d exp %0d", lat, LAT); end
        n_vec++; if (ang !== ea)  begin n_fail++; $display("FAIL post_rst_angle got %0d exp %0d", ang, ea); end
        n_vec++; if (mag !== em)  begin n_fail++; $display("FAIL post_rst_mag got %0d exp %0d", mag, em); end
        tick();
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
